gpio_in_debounce: RTL and testbench

Input conditioning stage directly upstream of the AHB GPIO peripheral. It synchronises the raw board switch/button inputs into HCLK and debounces each bit independently with a per-bit stability counter. It drives the debounced word onto the GPIO block's GPIOIN port, and produces per-bit edge pulses plus a sticky change interrupt for the CPU.

---
 rtl/gpio_in_debounce.sv | 67 ++++++
 tb/tb_gpio_in_debounce.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce: two-flop synchroniser plus per-bit stability counter feeding GPIOIN,
// with registered rise/fall pulses and a sticky change interrupt.
module gpio_in_debounce #(
   parameter int unsigned          WIDTH           = 16,
   parameter int unsigned          DEBOUNCE_CYCLES = 50000,
   parameter logic [WIDTH-1:0]     RESET_VAL       = {WIDTH{1'b0}},
   parameter int unsigned          CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic [WIDTH-1:0] RAW_IN,
   input  logic             IRQ_CLR,
   output logic [WIDTH-1:0] GPIOIN_DB,
   output logic [WIDTH-1:0] RISE_PULSE,
   output logic [WIDTH-1:0] FALL_PULSE,
   output logic             CHANGE_IRQ
);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] s1_q, s1_d, s2_q, s2_d;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;
   logic [WIDTH-1:0] at_max, accept;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];
   logic             irq_q, irq_d;

   // A level is accepted on the cycle its mismatch count reaches the limit; any match restarts it.
   always_comb begin
      s1_d = RAW_IN;
      s2_d = s1_q;
      for (int i = 0; i < WIDTH; i++) begin
         at_max[i] = cnt_q[i] == CNT_MAX;
         cnt_d[i]  = (s2_q[i] == stable_q[i] || at_max[i]) ? '0 : cnt_q[i] + 1'b1;
      end
      accept   = (s2_q ^ stable_q) & at_max;
      stable_d = stable_q ^ accept;
      rise_d   = accept & s2_q;
      fall_d   = accept & ~s2_q;
      irq_d    = |{rise_q, fall_q} ? 1'b1 : IRQ_CLR ? 1'b0 : irq_q;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         s1_q     <= RESET_VAL;
         s2_q     <= RESET_VAL;
         stable_q <= RESET_VAL;
         rise_q   <= '0;
         fall_q   <= '0;
         irq_q    <= 1'b0;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         stable_q <= stable_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         irq_q    <= irq_d;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign GPIOIN_DB  = stable_q;
   assign RISE_PULSE = rise_q;
   assign FALL_PULSE = fall_q;
   assign CHANGE_IRQ = irq_q;
endmodule

// File: tb/tb_gpio_in_debounce.sv
// tb_gpio_in_debounce: three instances (N=4, N=8, N=1) checked every cycle against a
// sliding-window acceptance model, plus hand-computed literal expectations.
module tb_gpio_in_debounce;
   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic [15:0] raw_a, raw_b;
   logic        clr_a, clr_b;
   logic [15:0] db [3];
   logic [15:0] rise [3];
   logic [15:0] fall [3];
   logic        irq [3];
   int          vectors = 0;
   int          miscompares = 0;

   always #5 HCLK = ~HCLK;

   gpio_in_debounce #(.WIDTH(16), .DEBOUNCE_CYCLES(4)) u_n4 (
      .HCLK(HCLK), .HRESETn(HRESETn), .RAW_IN(raw_a), .IRQ_CLR(clr_a),
      .GPIOIN_DB(db[0]), .RISE_PULSE(rise[0]), .FALL_PULSE(fall[0]), .CHANGE_IRQ(irq[0]));
   gpio_in_debounce #(.WIDTH(16), .DEBOUNCE_CYCLES(8)) u_n8 (
      .HCLK(HCLK), .HRESETn(HRESETn), .RAW_IN(raw_b), .IRQ_CLR(clr_b),
      .GPIOIN_DB(db[1]), .RISE_PULSE(rise[1]), .FALL_PULSE(fall[1]), .CHANGE_IRQ(irq[1]));
   gpio_in_debounce #(.WIDTH(16), .DEBOUNCE_CYCLES(1)) u_n1 (
      .HCLK(HCLK), .HRESETn(HRESETn), .RAW_IN(raw_a), .IRQ_CLR(clr_a),
      .GPIOIN_DB(db[2]), .RISE_PULSE(rise[2]), .FALL_PULSE(fall[2]), .CHANGE_IRQ(irq[2]));

   // Model: h[d][j] is the raw word sampled j+1 edges ago. A bit is accepted at an edge when the
   // synchronised level over the previous N cycles (raw samples 2..N+1 edges back) all differ from stable.
   logic [15:0] h [3][10];
   logic [15:0] m_st [3];
   logic [15:0] m_r [3];
   logic [15:0] m_f [3];
   logic        m_irq [3];

   function automatic int ns(input int d);
      return d == 0 ? 4 : d == 1 ? 8 : 1;
   endfunction

   function automatic logic [15:0] win(input int d);
      logic [15:0] a;
      a = 16'hFFFF;
      for (int j = 1; j <= ns(d); j++) a &= h[d][j] ^ m_st[d];
      return a;
   endfunction

   always @(posedge HCLK or negedge HRESETn) begin
      for (int d = 0; d < 3; d++) begin
         if (!HRESETn) begin
            for (int j = 0; j < 10; j++) h[d][j] <= 16'h0000;
            m_st[d]  <= 16'h0000;
            m_r[d]   <= 16'h0000;
            m_f[d]   <= 16'h0000;
            m_irq[d] <= 1'b0;
         end else begin
            m_irq[d] <= (m_r[d] | m_f[d]) != 16'h0 ? 1'b1 : (d == 1 ? clr_b : clr_a) ? 1'b0 : m_irq[d];
            m_r[d]   <= win(d) & ~m_st[d];
            m_f[d]   <= win(d) & m_st[d];
            m_st[d]  <= m_st[d] ^ win(d);
            for (int j = 9; j > 0; j--) h[d][j] <= h[d][j-1];
            h[d][0]  <= d == 1 ? raw_b : raw_a;
         end
      end
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge HCLK) begin
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("db[%0d]", d), db[d], m_st[d]);
         chk($sformatf("rise[%0d]", d), rise[d], m_r[d]);
         chk($sformatf("fall[%0d]", d), fall[d], m_f[d]);
         chk($sformatf("irq[%0d]", d), {15'h0, irq[d]}, {15'h0, m_irq[d]});
      end
   end

   task automatic edges(input int n);
      repeat (n) @(posedge HCLK);
      #1;
   endtask

   initial begin
      HRESETn = 1'b0;
      raw_a = 16'hFFFF;
      raw_b = 16'h0000;
      clr_a = 1'b0;
      clr_b = 1'b0;
      edges(3);
      chk("rst_db", db[0], 16'h0000);
      chk("rst_rise", rise[0], 16'h0000);
      chk("rst_irq", {15'h0, irq[0]}, 16'h0000);
      HRESETn = 1'b1;
      edges(5);
      chk("rst_rel_db_E4", db[0], 16'h0000);
      edges(1);
      chk("rst_rel_db_E5", db[0], 16'hFFFF);
      chk("rst_rel_rise_E5", rise[0], 16'hFFFF);
      edges(1);
      chk("rst_rel_rise_E6", rise[0], 16'h0000);
      chk("rst_rel_irq_E6", {15'h0, irq[0]}, 16'h0001);
      clr_a = 1'b1;
      edges(1);
      clr_a = 1'b0;
      chk("irq_clr", {15'h0, irq[0]}, 16'h0000);
      // clean edge on bit 3
      raw_a = 16'h0000;
      edges(6);
      chk("fall_all", fall[0], 16'hFFFF);
      edges(4);
      raw_a = 16'h0008;
      edges(2);
      chk("n1_db_E1", db[2], 16'h0000);
      edges(1);
      chk("n1_db_E2", db[2], 16'h0008);
      edges(2);
      chk("clean_db_E4", db[0], 16'h0000);
      edges(1);
      chk("clean_db_E5", db[0], 16'h0008);
      chk("clean_rise", rise[0], 16'h0008);
      chk("clean_fall", fall[0], 16'h0000);
      edges(1);
      chk("clean_rise_off", rise[0], 16'h0000);
      clr_a = 1'b1;
      edges(1);
      clr_a = 1'b0;
      chk("irq_clr2", {15'h0, irq[0]}, 16'h0000);
      // glitch rejection on bit 0
      raw_a = 16'h0009; edges(3);
      raw_a = 16'h0008; edges(1);
      raw_a = 16'h0009; edges(3);
      raw_a = 16'h0008; edges(8);
      chk("glitch_db", db[0], 16'h0008);
      chk("glitch_irq", {15'h0, irq[0]}, 16'h0000);
      raw_a = 16'h0009;
      edges(6);
      chk("glitch_accept_db", db[0], 16'h0009);
      chk("glitch_accept_rise", rise[0], 16'h0001);
      // simultaneous rise on bit 0 and fall on bit 15
      raw_a = 16'h8008;
      edges(8);
      raw_a = 16'h0009;
      edges(6);
      chk("simul_rise", rise[0], 16'h0001);
      chk("simul_fall", fall[0], 16'h8000);
      chk("simul_db", db[0], 16'h0009);
      // clear priority
      edges(2);
      clr_a = 1'b1;
      edges(1);
      clr_a = 1'b0;
      chk("prio_pre_clr", {15'h0, irq[0]}, 16'h0000);
      raw_a = 16'h0008;
      edges(6);
      chk("prio_fall", fall[0], 16'h0001);
      clr_a = 1'b1;
      edges(1);
      chk("prio_set_wins", {15'h0, irq[0]}, 16'h0001);
      edges(1);
      clr_a = 1'b0;
      chk("prio_clr_after", {15'h0, irq[0]}, 16'h0000);
      // reset mid-count on the N=8 instance
      raw_b = 16'h0020;
      edges(7);
      HRESETn = 1'b0;
      #1;
      chk("midrst_db", db[1], 16'h0000);
      chk("midrst_rise", rise[1], 16'h0000);
      edges(2);
      HRESETn = 1'b1;
      edges(9);
      chk("midrst_db_E8", db[1], 16'h0000);
      edges(1);
      chk("midrst_db_E9", db[1], 16'h0020);
      chk("midrst_rise_E9", rise[1], 16'h0020);
      edges(3);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
